// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the single-bus datapath.
// ALU op codes, bus-source request indices, IR field positions.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam int SRC_HI  = 16;
  localparam int SRC_LO  = 17;
  localparam int SRC_ZHI = 18;
  localparam int SRC_ZLO = 19;
  localparam int SRC_PC  = 20;
  localparam int SRC_MDR = 21;
  localparam int SRC_INP = 22;
  localparam int SRC_C   = 23;

  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;
  localparam int C_MSB   = 18;
  localparam int CND_LSB = 19;

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU, A = Y, B = bus, 64-bit result for Z.
// Ports: op_i (op code), a_i, b_i (operands), res_o (Z image).
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o
);

  logic [4:0]  sh;
  logic [5:0]  sh_c;
  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] lo;

  assign sh   = b_i[4:0];
  assign sh_c = 6'd32 - {1'b0, sh};
  assign prod = $signed({{32{a_i[31]}}, a_i}) *
                $signed({{32{b_i[31]}}, b_i});

  // Divide by zero yields a zero quotient and remainder.
  always_comb begin
    quot = '0;
    rem  = '0;
    if (b_i != '0) begin
      quot = $signed(a_i) / $signed(b_i);
      rem  = $signed(a_i) % $signed(b_i);
    end
  end

  // A shift by 32 clears, so sh == 0 rotates to A itself.
  always_comb begin
    lo = b_i;
    case (op_i)
      OP_ADD:  lo = a_i + b_i;
      OP_SUB:  lo = a_i - b_i;
      OP_AND:  lo = a_i & b_i;
      OP_OR:   lo = a_i | b_i;
      OP_ROR:  lo = (a_i >> sh) | (a_i << sh_c);
      OP_ROL:  lo = (a_i << sh) | (a_i >> sh_c);
      OP_SHR:  lo = a_i >> sh;
      OP_SHRA: lo = $signed(a_i) >>> sh;
      OP_SHL:  lo = a_i << sh;
      OP_NEG:  lo = 32'd0 - b_i;
      OP_NOT:  lo = ~b_i;
      default: lo = b_i;
    endcase
    res_o = {32'd0, lo};
    if (op_i == OP_MUL) res_o = prod;
    if (op_i == OP_DIV) res_o = {rem, quot};
  end

endmodule

// File: rtl/cpu_datapath_units.sv
// Small datapath units: 4-to-16 decoder, register select/encode,
// bus priority encoder and the MDR register.
module cpu_dec4to16 (
  input  logic [3:0]  sel_i,
  output logic [15:0] decoderOutput
);
  assign decoderOutput = 16'h1 << sel_i;
endmodule

module cpu_sel_encode
  import cpu_pkg::*;
(
  input  logic [31:0] ir_i,
  input  logic        gra_i,
  input  logic        grb_i,
  input  logic        grc_i,
  input  logic        rin_i,
  input  logic        rout_i,
  input  logic        baout_i,
  output logic [15:0] RinSignals,
  output logic [15:0] RoutSignals
);
  logic [3:0]  field;
  logic [15:0] dec;
  logic        unused_ir;

  assign field = (ir_i[RA_LSB +: 4] & {4{gra_i}})
               | (ir_i[RB_LSB +: 4] & {4{grb_i}})
               | (ir_i[RC_LSB +: 4] & {4{grc_i}});

  cpu_dec4to16 decoder (
    .sel_i        (field),
    .decoderOutput(dec)
  );

  assign RinSignals  = dec & {16{rin_i}};
  assign RoutSignals = dec & {16{rout_i | baout_i}};
  assign unused_ir   = ^{ir_i[31:27], ir_i[14:0]};
endmodule

module cpu_bus_encoder (
  input  logic [31:0] encoderInput,
  output logic [4:0]  encoderOutput,
  output logic        valid_o
);
  // Scan downward so the lowest requesting index is the survivor.
  always_comb begin
    encoderOutput = '0;
    for (int i = 31; i >= 0; i--)
      if (encoderInput[i]) encoderOutput = 5'(i);
  end
  assign valid_o = |encoderInput;
endmodule

module cpu_mdr (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mdrin_i,
  input  logic        read_i,
  input  logic [31:0] bus_i,
  input  logic [31:0] mem_i,
  output logic [31:0] MDRout
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      MDRout <= '0;
    else if (mdrin_i) MDRout <= read_i ? mem_i : bus_i;
  end
endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: single-bus 32-bit datapath with GPRs, PC/IR/MAR/MDR/Y/Z/HI/LO, ALU, RAM.
// Strobe inputs from the control unit; outputs encoder_input (debug) and CON_in. Macro: CPU_MEM_INIT_EN.
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int MEM_WORDS = 512,
  parameter     MEM_FILE  = "program.hex"
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        ZHighout,
  input  logic        MDRout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        Cout,
  input  logic        InPortout,
  input  logic        MARin,
  input  logic        Zin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        Write,
  input  logic        AND,
  input  logic        GRA,
  input  logic        GRB,
  input  logic        GRC,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic [4:0]  operation,
  input  logic [15:0] Register_enable_Signals,
  output logic [31:0] encoder_input,
  output logic        CON_in
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int unused_file_bits = $bits(MEM_FILE);

  logic [31:0] gpr_q [16];
  logic [31:0] R0_data_out, R1_data_out, R2_data_out, R3_data_out;
  logic [31:0] R4_data_out, R5_data_out, R6_data_out, R7_data_out;
  logic [31:0] R8_data_out, R9_data_out, R10_data_out, R11_data_out;
  logic [31:0] R12_data_out, R13_data_out, R14_data_out, R15_data_out;
  logic [31:0] PC_data_out, IR_data_out, Y_data_out, MAR_data_out;
  logic [31:0] ZLow_data_out, ZHigh_data_out;
  logic [31:0] HI_data_out, LO_data_out;
  logic [31:0] bus_data, C_sign_extended, c_data_out;
  logic [31:0] mdr_q, mem_rd;
  logic [15:0] ir_enable_signals, ir_output_signals, rin_dec;
  logic [31:0] enc_in;
  logic [4:0]  enc_out;
  logic        enc_vld;
  logic [63:0] alu_res;
  logic [4:0]  alu_op;
  logic        muldiv;
  logic        unused_mar;
  logic [31:0] ram [MEM_WORDS];

  assign R0_data_out  = gpr_q[0];
  assign R1_data_out  = gpr_q[1];
  assign R2_data_out  = gpr_q[2];
  assign R3_data_out  = gpr_q[3];
  assign R4_data_out  = gpr_q[4];
  assign R5_data_out  = gpr_q[5];
  assign R6_data_out  = gpr_q[6];
  assign R7_data_out  = gpr_q[7];
  assign R8_data_out  = gpr_q[8];
  assign R9_data_out  = gpr_q[9];
  assign R10_data_out = gpr_q[10];
  assign R11_data_out = gpr_q[11];
  assign R12_data_out = gpr_q[12];
  assign R13_data_out = gpr_q[13];
  assign R14_data_out = gpr_q[14];
  assign R15_data_out = gpr_q[15];

  assign C_sign_extended = {{(31-C_MSB){IR_data_out[C_MSB]}},
                            IR_data_out[C_MSB:0]};
  assign c_data_out = C_sign_extended;
  assign unused_mar = ^MAR_data_out[31:AW];

  cpu_sel_encode ir_encode (
    .ir_i       (IR_data_out),
    .gra_i      (GRA),
    .grb_i      (GRB),
    .grc_i      (GRC),
    .rin_i      (Rin),
    .rout_i     (Rout),
    .baout_i    (BAout),
    .RinSignals (rin_dec),
    .RoutSignals(ir_output_signals)
  );

  assign ir_enable_signals = rin_dec | Register_enable_Signals;

  always_comb begin
    enc_in          = '0;
    enc_in[15:0]    = ir_output_signals;
    enc_in[SRC_HI]  = HIout;
    enc_in[SRC_LO]  = LOout;
    enc_in[SRC_ZHI] = ZHighout;
    enc_in[SRC_ZLO] = Zlowout;
    enc_in[SRC_PC]  = PCout;
    enc_in[SRC_MDR] = MDRout;
    enc_in[SRC_INP] = InPortout;
    enc_in[SRC_C]   = Cout;
  end

  assign encoder_input = enc_in;

  cpu_bus_encoder bus_encoder (
    .encoderInput (enc_in),
    .encoderOutput(enc_out),
    .valid_o      (enc_vld)
  );

  always_comb begin
    bus_data = '0;
    if (enc_vld && !enc_out[4]) begin
      if (enc_out[3:0] == 4'd0 && BAout) bus_data = '0;
      else bus_data = gpr_q[enc_out[3:0]];
    end else if (enc_vld) begin
      case (enc_out)
        5'(SRC_HI):  bus_data = HI_data_out;
        5'(SRC_LO):  bus_data = LO_data_out;
        5'(SRC_ZHI): bus_data = ZHigh_data_out;
        5'(SRC_ZLO): bus_data = ZLow_data_out;
        5'(SRC_PC):  bus_data = PC_data_out;
        5'(SRC_MDR): bus_data = mdr_q;
        5'(SRC_C):   bus_data = C_sign_extended;
        default:     bus_data = '0;
      endcase
    end
  end

  assign alu_op = AND ? OP_AND : operation;
  assign muldiv = (alu_op == OP_MUL) || (alu_op == OP_DIV);

  cpu_alu alu (
    .op_i (alu_op),
    .a_i  (Y_data_out),
    .b_i  (bus_data),
    .res_o(alu_res)
  );

  cpu_mdr mdr_unit (
    .clk_i  (Clock),
    .rst_ni (Resetn),
    .mdrin_i(MDRin),
    .read_i (Read),
    .bus_i  (bus_data),
    .mem_i  (mem_rd),
    .MDRout (mdr_q)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 16; i++) gpr_q[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (ir_enable_signals[i]) gpr_q[i] <= bus_data;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      PC_data_out    <= '0;
      IR_data_out    <= '0;
      Y_data_out     <= '0;
      MAR_data_out   <= '0;
      ZLow_data_out  <= '0;
      ZHigh_data_out <= '0;
      HI_data_out    <= '0;
      LO_data_out    <= '0;
    end else begin
      if (PCin)  PC_data_out  <= IncPC ? PC_data_out + 32'd1 : bus_data;
      if (IRin)  IR_data_out  <= bus_data;
      if (Yin)   Y_data_out   <= bus_data;
      if (MARin) MAR_data_out <= bus_data;
      if (Zin) begin
        {ZHigh_data_out, ZLow_data_out} <= alu_res;
        if (muldiv) begin
          HI_data_out <= alu_res[63:32];
          LO_data_out <= alu_res[31:0];
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Write) ram[MAR_data_out[AW-1:0]] <= mdr_q;
  end

  assign mem_rd = ram[MAR_data_out[AW-1:0]];

  always_comb begin
    case (IR_data_out[CND_LSB +: 2])
      2'b00:   CON_in = (bus_data == '0);
      2'b01:   CON_in = (bus_data != '0);
      2'b10:   CON_in = ~bus_data[31];
      default: CON_in = bus_data[31];
    endcase
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed and random checks of cpu_datapath
// against a behavioural model of the bus, registers and ALU.
module tb_cpu_datapath;

  logic        Clock, Resetn;
  logic        PCout, Zlowout, ZHighout, MDRout, HIout, LOout;
  logic        Cout, InPortout, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic        IncPC, Read, Write, AND, GRA, GRB, GRC, Rin, Rout, BAout;
  logic [4:0]  operation;
  logic [15:0] Register_enable_Signals;
  logic [31:0] encoder_input;
  logic        CON_in;

  int n_tests = 0;
  int n_fail  = 0;
  int m_mar   = 0;
  logic [31:0] exp_r [16];
  logic [31:0] m_hi, m_lo;
  logic [31:0] r_obs [16];
  logic [4:0]  ops [15] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                            5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18,
                            5'd0, 5'd31};

  cpu_datapath dut (
    .Clock(Clock), .Resetn(Resetn),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout),
    .MDRout(MDRout), .HIout(HIout), .LOout(LOout), .Cout(Cout),
    .InPortout(InPortout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC),
    .Read(Read), .Write(Write), .AND(AND), .GRA(GRA), .GRB(GRB),
    .GRC(GRC), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .operation(operation),
    .Register_enable_Signals(Register_enable_Signals),
    .encoder_input(encoder_input), .CON_in(CON_in)
  );

  assign r_obs[0]  = dut.R0_data_out;
  assign r_obs[1]  = dut.R1_data_out;
  assign r_obs[2]  = dut.R2_data_out;
  assign r_obs[3]  = dut.R3_data_out;
  assign r_obs[4]  = dut.R4_data_out;
  assign r_obs[5]  = dut.R5_data_out;
  assign r_obs[6]  = dut.R6_data_out;
  assign r_obs[7]  = dut.R7_data_out;
  assign r_obs[8]  = dut.R8_data_out;
  assign r_obs[9]  = dut.R9_data_out;
  assign r_obs[10] = dut.R10_data_out;
  assign r_obs[11] = dut.R11_data_out;
  assign r_obs[12] = dut.R12_data_out;
  assign r_obs[13] = dut.R13_data_out;
  assign r_obs[14] = dut.R14_data_out;
  assign r_obs[15] = dut.R15_data_out;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    {PCout, Zlowout, ZHighout, MDRout, HIout, LOout} = '0;
    {Cout, InPortout, MARin, Zin, PCin, MDRin, IRin, Yin} = '0;
    {IncPC, Read, Write, AND, GRA, GRB, GRC} = '0;
    {Rin, Rout, BAout} = '0;
    operation = '0;
    Register_enable_Signals = '0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    clr();
  endtask

  task automatic put_mdr(input logic [31:0] v);
    dut.ram[m_mar] = v;
    Read = 1; MDRin = 1;
    step();
  endtask

  task automatic set_ir(input logic [31:0] v);
    put_mdr(v);
    MDRout = 1; IRin = 1;
    step();
  endtask

  task automatic alu_run(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic force_and);
    put_mdr(a);
    MDRout = 1; Yin = 1;
    step();
    put_mdr(b);
    MDRout = 1; Zin = 1; operation = op; AND = force_and;
    step();
  endtask

  function automatic logic [63:0] ref_alu(input logic [4:0] op,
    input logic [31:0] a, input logic [31:0] b);
    int n;
    longint sa, sb, q, r;
    logic [31:0] y;
    n  = int'(b[4:0]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    y  = b;
    case (op)
      5'd3:  y = a + b;
      5'd4:  y = a - b;
      5'd5:  y = a & b;
      5'd6:  y = a | b;
      5'd7:  y = (n == 0) ? a : (a >> n) | (a << (32 - n));
      5'd8:  y = (n == 0) ? a : (a << n) | (a >> (32 - n));
      5'd9:  y = a >> n;
      5'd10: y = 32'(sa >>> n);
      5'd11: y = a << n;
      5'd15: return 64'(sa * sb);
      5'd16: begin
        if (sb == 0) return 64'd0;
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      5'd17: y = 32'd0 - b;
      5'd18: y = ~b;
      default: y = b;
    endcase
    return {32'd0, y};
  endfunction

  initial begin
    logic [31:0] a, b, v, ir;
    logic [63:0] e;
    logic [4:0]  op, eop;
    logic        fa, econ;
    int          r, c;

    clr();
    Resetn = 0;
    for (int i = 0; i < 16; i++) exp_r[i] = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_pc", dut.PC_data_out, 0);
    chk("rst_ir", dut.IR_data_out, 0);
    chk("rst_bus", dut.bus_data, 0);
    chk("rst_enc", encoder_input, 0);
    chk("rst_con", CON_in, 1);
    @(negedge Clock);
    Resetn = 1;
    step();

    // fetch
    dut.ram[0] = 32'h7228_0054;
    PCout = 1; MARin = 1; IncPC = 1; PCin = 1;
    #1;
    chk("fetch_enc", encoder_input, 32'h0010_0000);
    chk("fetch_bus", dut.bus_data, 0);
    step();
    chk("fetch_pc", dut.PC_data_out, 1);
    chk("fetch_mar", dut.MAR_data_out, 0);
    Read = 1; MDRin = 1;
    step();
    chk("fetch_mdr", dut.mdr_unit.MDRout, 32'h7228_0054);
    MDRout = 1; IRin = 1;
    step();
    chk("fetch_ir", dut.IR_data_out, 32'h7228_0054);
    chk("fetch_c", dut.C_sign_extended, 32'h0000_0054);

    // ori R4, R5, 0x54
    put_mdr(32'h23);
    MDRout = 1; Register_enable_Signals = 16'h0020;
    step();
    GRB = 1; Rout = 1; Yin = 1;
    step();
    chk("ori_y", dut.Y_data_out, 32'h23);
    Cout = 1; operation = 5'b00110; Zin = 1;
    #1;
    chk("ori_cbus", dut.bus_data, 32'h54);
    chk("ori_con", CON_in, 1);
    step();
    Zlowout = 1; GRA = 1; Rin = 1;
    step();
    chk("ori_r4", r_obs[4], 32'h77);
    exp_r[4] = 32'h77;
    exp_r[5] = 32'h23;

    // random GPR writes/readbacks
    for (int k = 0; k < 16; k++) begin
      r = $urandom_range(0, 15);
      v = $urandom;
      if (k % 2 == 0) begin
        put_mdr(v);
        MDRout = 1; Register_enable_Signals = 16'(1 << r);
        step();
      end else begin
        set_ir(32'(r) << 15);
        put_mdr(v);
        MDRout = 1; GRC = 1; Rin = 1;
        step();
      end
      exp_r[r] = v;
      set_ir(32'(r) << 19);
      GRB = 1; Rout = 1;
      #1;
      chk("gpr_rd", dut.bus_data, v);
      clr();
    end
    put_mdr(32'h1234_5678);
    MDRout = 1; Register_enable_Signals = 16'h0001;
    step();
    exp_r[0] = 32'h1234_5678;
    for (int i = 0; i < 16; i++)
      chk($sformatf("gpr_r%0d", i), r_obs[i], exp_r[i]);

    // sign extension, BAout on R0, CON
    set_ir(32'h0007_FFFF);
    chk("sx_c", dut.C_sign_extended, 32'hFFFF_FFFF);
    Cout = 1;
    #1;
    chk("sx_bus", dut.bus_data, 32'hFFFF_FFFF);
    chk("sx_con", CON_in, 0);
    clr();
    GRA = 1; BAout = 1;
    #1;
    chk("ba_r0", dut.bus_data, 0);
    chk("ba_con", CON_in, 1);
    clr();
    GRA = 1; Rout = 1;
    #1;
    chk("rout_r0", dut.bus_data, exp_r[0]);
    clr();

    // mul / div
    alu_run(32'hFFFF_FFFE, 32'd3, 5'b01111, 1'b0);
    chk("mul_zhi", dut.ZHigh_data_out, 32'hFFFF_FFFF);
    chk("mul_zlo", dut.ZLow_data_out, 32'hFFFF_FFFA);
    chk("mul_hi", dut.HI_data_out, 32'hFFFF_FFFF);
    chk("mul_lo", dut.LO_data_out, 32'hFFFF_FFFA);
    alu_run(32'd9, 32'd0, 5'b10000, 1'b0);
    chk("div0_hi", dut.HI_data_out, 0);
    chk("div0_lo", dut.LO_data_out, 0);
    alu_run(32'd7, 32'd2, 5'b10000, 1'b0);
    chk("div_lo", dut.LO_data_out, 3);
    chk("div_hi", dut.HI_data_out, 1);
    alu_run(32'd1, 32'd2, 5'b00011, 1'b0);
    chk("add_zlo", dut.ZLow_data_out, 3);
    chk("add_zhi", dut.ZHigh_data_out, 0);
    chk("add_hi", dut.HI_data_out, 1);
    m_hi = 32'd1; m_lo = 32'd3;

    // bus priority (IR Rc = 15)
    GRC = 1; Rout = 1; HIout = 1; PCout = 1;
    #1;
    chk("pri_enc1", encoder_input, 32'h0011_8000);
    chk("pri_bus1", dut.bus_data, exp_r[15]);
    clr();
    HIout = 1; PCout = 1; Cout = 1;
    #1;
    chk("pri_enc2", encoder_input, 32'h0091_0000);
    chk("pri_bus2", dut.bus_data, 1);
    clr();
    LOout = 1; ZHighout = 1;
    #1;
    chk("pri_bus3", dut.bus_data, 3);
    clr();
    InPortout = 1;
    #1;
    chk("inport_bus", dut.bus_data, 0);
    chk("inport_enc", encoder_input, 32'h0040_0000);
    clr();

    // PC load / increment priority / wrap
    Cout = 1; PCin = 1;
    step();
    chk("pc_load", dut.PC_data_out, 32'hFFFF_FFFF);
    Cout = 1; PCin = 1; IncPC = 1;
    step();
    chk("pc_wrap", dut.PC_data_out, 0);
    IncPC = 1;
    step();
    chk("pc_hold", dut.PC_data_out, 0);
    PCin = 1; IncPC = 1;
    step();
    chk("pc_inc", dut.PC_data_out, 1);

    // random ALU
    for (int k = 0; k < 48; k++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(0, 40);
        1: b = 32'd0 - $urandom_range(0, 9);
        default: ;
      endcase
      op = ops[$urandom_range(0, 14)];
      fa = ($urandom_range(0, 7) == 0);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      alu_run(a, b, op, fa);
      eop = fa ? 5'd5 : op;
      e = ref_alu(eop, a, b);
      if (eop == 5'd15 || eop == 5'd16) begin
        m_hi = e[63:32];
        m_lo = e[31:0];
      end
      chk($sformatf("alu_zlo op%0d", eop), dut.ZLow_data_out, e[31:0]);
      chk($sformatf("alu_zhi op%0d", eop), dut.ZHigh_data_out, e[63:32]);
      chk("alu_hi", dut.HI_data_out, m_hi);
      chk("alu_lo", dut.LO_data_out, m_lo);
    end

    // random CON
    for (int k = 0; k < 16; k++) begin
      c  = $urandom_range(0, 3);
      ir = ($urandom & ~32'h0018_0000) | (32'(c) << 19);
      set_ir(ir);
      v = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      put_mdr(v);
      case (c)
        0: econ = (v == 0);
        1: econ = (v != 0);
        2: econ = ($signed(v) >= 0);
        default: econ = ($signed(v) < 0);
      endcase
      MDRout = 1;
      #1;
      chk("con_bus", dut.bus_data, v);
      chk($sformatf("con_c%0d", c), CON_in, econ);
      clr();
    end

    // store, and Write with MDRin in the same cycle
    put_mdr(32'd5);
    MDRout = 1; Zin = 1;
    step();
    put_mdr(32'hDEAD_BEEF);
    dut.ram[5] = 32'd0;
    Zlowout = 1; MARin = 1;
    step();
    m_mar = 5;
    chk("st_mar", dut.MAR_data_out, 5);
    Write = 1; MDRin = 1; Zlowout = 1;
    step();
    chk("st_ram", dut.ram[5], 32'hDEAD_BEEF);
    chk("st_mdr", dut.mdr_unit.MDRout, 5);
    Read = 1; MDRin = 1;
    step();
    chk("ld_mdr", dut.mdr_unit.MDRout, 32'hDEAD_BEEF);

    // asynchronous reset mid-run
    Resetn = 0;
    #1;
    chk("mrst_pc", dut.PC_data_out, 0);
    chk("mrst_ir", dut.IR_data_out, 0);
    chk("mrst_zlo", dut.ZLow_data_out, 0);
    chk("mrst_zhi", dut.ZHigh_data_out, 0);
    chk("mrst_hi", dut.HI_data_out, 0);
    chk("mrst_lo", dut.LO_data_out, 0);
    chk("mrst_mar", dut.MAR_data_out, 0);
    chk("mrst_y", dut.Y_data_out, 0);
    chk("mrst_mdr", dut.mdr_unit.MDRout, 0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("mrst_r%0d", i), r_obs[i], 0);
    chk("mrst_ram", dut.ram[5], 32'hDEAD_BEEF);
    #3;
    Resetn = 1;
    m_mar = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
